// File: rtl/lvds_word_aligner.sv
// Word aligner behind the 12-bit LVDS deserializer: bitslip search on a training word, verify, lock.
// Define LVDS_ALIGN_ERR_CNT_EN to add err_cnt, a saturating count of pattern misses while locked.
//   state    | meaning
//   S_SEARCH | compare candidate at slip_pos, advance slip on a miss
//   S_WAIT   | compares blanked for SLIP_WAIT valid cycles after a slip
//   S_VERIFY | counting consecutive matches towards LOCK_COUNT
//   S_LOCKED | slip frozen, data_valid follows in_valid, misses monitored when train_en=1
module lvds_word_aligner #(
  parameter int                 WIDTH         = 12,
  parameter logic [WIDTH-1:0]   TRAIN_PATTERN = 12'hF00,
  parameter int                 LOCK_COUNT    = 8,
  parameter int                 LOSS_COUNT    = 4,
  parameter int                 SLIP_WAIT     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             train_en,
  input  logic             realign,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             locked,
  output logic [3:0]       slip_pos
`ifdef LVDS_ALIGN_ERR_CNT_EN
  , output logic [15:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {S_SEARCH, S_WAIT, S_VERIFY, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       slip_q, slip_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dvalid_q, dvalid_d;
  logic             locked_q, locked_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic [2:0]       wait_q, wait_d;

  logic [2*WIDTH-1:0] window;
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   candidate;
  logic               hit;
  logic [3:0]         slip_next;
  state_t             after_slip;

  // Previous word sits in the low half so slip 0 selects it unchanged.
  assign window    = {in_data, prev_q};
  assign shifted   = window >> slip_q;
  assign candidate = shifted[WIDTH-1:0];
  assign hit       = (candidate == TRAIN_PATTERN);
  assign slip_next = (slip_q == 4'(WIDTH - 1)) ? 4'd0 : slip_q + 4'd1;
  assign after_slip = (SLIP_WAIT == 0) ? S_SEARCH : S_WAIT;

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    prev_d   = prev_q;
    data_d   = data_q;
    match_d  = match_q;
    miss_d   = miss_q;
    wait_d   = wait_q;
    dvalid_d = (state_q == S_LOCKED) && in_valid;

    if (in_valid) begin
      prev_d = in_data;
      data_d = candidate;
    end

    if (realign) begin
      state_d = S_SEARCH;
      match_d = 8'd0;
      miss_d  = 8'd0;
      wait_d  = 3'd0;
    end else if (in_valid) begin
      case (state_q)
        S_SEARCH: begin
          if (hit) begin
            if (LOCK_COUNT == 1) begin
              state_d = S_LOCKED;
            end else begin
              state_d = S_VERIFY;
              match_d = 8'd1;
            end
          end else begin
            slip_d  = slip_next;
            state_d = after_slip;
            wait_d  = 3'(SLIP_WAIT);
          end
        end
        S_WAIT: begin
          if (wait_q <= 3'd1) begin
            state_d = S_SEARCH;
            wait_d  = 3'd0;
          end else begin
            wait_d = wait_q - 3'd1;
          end
        end
        S_VERIFY: begin
          if (hit) begin
            if (match_q + 8'd1 == 8'(LOCK_COUNT)) begin
              state_d = S_LOCKED;
              match_d = 8'd0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            slip_d  = slip_next;
            match_d = 8'd0;
            state_d = after_slip;
            wait_d  = 3'(SLIP_WAIT);
          end
        end
        S_LOCKED: begin
          if (train_en && !hit) begin
            if (miss_q + 8'd1 == 8'(LOSS_COUNT)) begin
              state_d = S_SEARCH;
              miss_d  = 8'd0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = 8'd0;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

`ifdef LVDS_ALIGN_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (realign) begin
      err_d = 16'd0;
    end else if (in_valid && (state_q == S_LOCKED) && train_en && !hit && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 16'd0;
    else      err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_SEARCH;
      slip_q   <= 4'd0;
      prev_q   <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      locked_q <= 1'b0;
      match_q  <= 8'd0;
      miss_q   <= 8'd0;
      wait_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      slip_q   <= slip_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      locked_q <= locked_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      wait_q   <= wait_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dvalid_q;
  assign locked     = locked_q;
  assign slip_pos   = slip_q;

endmodule

// File: tb/tb_lvds_word_aligner.sv
// Scoreboard bench for lvds_word_aligner: a behavioural alignment model predicts every cycle,
// a monitor compares DUT outputs one edge later.
module tb_lvds_word_aligner;
  localparam logic [11:0] PAT    = 12'hF00;
  localparam int          LOCK_N = 8;
  localparam int          LOSS_N = 4;
  localparam int          BLANK  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        train_en = 1'b0;
  logic        realign = 1'b0;
  logic [11:0] data_out;
  logic        data_valid;
  logic        locked;
  logic [3:0]  slip_pos;
`ifdef LVDS_ALIGN_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  lvds_word_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .train_en   (train_en),
    .realign    (realign),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .slip_pos   (slip_pos)
`ifdef LVDS_ALIGN_ERR_CNT_EN
    , .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] dout;
    logic        dv;
    logic        lk;
    logic [3:0]  slip;
    logic [15:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: alignment described as "blanking left", "hits so far", "misses so far".
  logic [11:0] m_prev;
  logic [11:0] m_dout;
  int          m_slip, m_hits, m_miss, m_blank, m_err;
  bit          m_dv, m_locked;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] rotl(input logic [11:0] x, input int s);
    logic [23:0] dbl;
    dbl = {x, x} << s;
    return dbl[23:12];
  endfunction

  task automatic model_clear();
    m_prev = '0; m_dout = '0; m_slip = 0; m_hits = 0; m_miss = 0;
    m_blank = 0; m_err = 0; m_dv = 0; m_locked = 0;
  endtask

  task automatic model_step(input logic [11:0] d, input bit v, input bit tr, input bit ra);
    logic [23:0] win;
    logic [11:0] cand;
    bit          match;
    win   = {d, m_prev} >> m_slip;
    cand  = win[11:0];
    match = (cand == PAT);
    m_dv  = m_locked && v;
    if (v) begin
      m_dout = cand;
      m_prev = d;
    end
    if (ra) begin
      m_locked = 0; m_hits = 0; m_miss = 0; m_blank = 0; m_err = 0;
    end else if (v) begin
      if (m_locked) begin
        if (tr && !match) begin
          m_miss++;
          if (m_err < 65535) m_err++;
          if (m_miss == LOSS_N) begin
            m_locked = 0;
            m_miss   = 0;
          end
        end else begin
          m_miss = 0;
        end
      end else if (m_blank > 0) begin
        m_blank--;
      end else if (match) begin
        m_hits++;
        if (m_hits == LOCK_N) begin
          m_locked = 1;
          m_hits   = 0;
        end
      end else begin
        m_slip  = (m_slip + 1) % 12;
        m_hits  = 0;
        m_blank = BLANK;
      end
    end
  endtask

  task automatic drive(input logic [11:0] d, input bit v, input bit tr, input bit ra);
    exp_t e;
    @(negedge clk);
    in_data = d; in_valid = v; train_en = tr; realign = ra;
    model_step(d, v, tr, ra);
    e.dout = m_dout; e.dv = m_dv; e.lk = m_locked; e.slip = 4'(m_slip); e.err = 16'(m_err);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_slip_pos"}, slip_pos, 0);
`ifdef LVDS_ALIGN_ERR_CNT_EN
    check({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  // Asserts reset between clock edges and checks that outputs clear without waiting for an edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero({tag, "_async"});
    model_clear();
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      in_data = 12'($urandom); in_valid = 1'($urandom); train_en = 1'($urandom);
    end
    settle();
    check_zero({tag, "_held"});
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; realign = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("data_out", data_out, e.dout);
      check("data_valid", data_valid, e.dv);
      check("locked", locked, e.lk);
      check("slip_pos", slip_pos, e.slip);
`ifdef LVDS_ALIGN_ERR_CNT_EN
      check("err_cnt", err_cnt, e.err);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench still running at t=%0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] w5, w, d;
    int          s, r, err_before;
    bit          v, tr, ra;

    model_clear();
    do_reset("reset");

    // Continuous training word at offset 0 (window starts with a zero prev word).
    for (int i = 0; i < 60; i++) drive(PAT, 1, 1, 0);
    settle();
    check("off0_locked", locked, 1);
    check("off0_slip", slip_pos, 0);
    check("off0_data", data_out, PAT);

    // Training word embedded at offset 5.
    do_reset("reset2");
    w5 = rotl(PAT, 5);
    for (int i = 0; i < 40; i++) drive(w5, 1, 1, 0);
    settle();
    check("off5_locked", locked, 1);
    check("off5_slip", slip_pos, 5);
    check("off5_data", data_out, PAT);

    // Loss of lock: 3 misses then a hit keeps lock, 4 misses drop it.
    for (int i = 0; i < 3; i++) drive(w5 ^ 12'h001, 1, 1, 0);
    drive(w5, 1, 1, 0);
    settle();
    check("loss_hold_locked", locked, 1);
`ifdef LVDS_ALIGN_ERR_CNT_EN
    err_before = int'(err_cnt);
`else
    err_before = 0;
`endif
    for (int i = 0; i < 4; i++) drive(w5 ^ 12'h001, 1, 1, 0);
    settle();
    check("loss_locked", locked, 0);
    check("loss_slip", slip_pos, 5);
`ifdef LVDS_ALIGN_ERR_CNT_EN
    check("loss_err_delta", err_cnt, 16'(err_before + 4));
`endif

    // Relock, then random payload with train_en=0 and some in_valid gaps.
    for (int i = 0; i < 10; i++) drive(w5, 1, 1, 0);
    for (int i = 0; i < 100; i++) drive(12'($urandom), 1, 0, 0);
    settle();
    check("payload_locked", locked, 1);
    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(0, 2) != 0);
      drive(12'($urandom), v, 0, 0);
    end
    settle();
    check("gap_slip", slip_pos, 5);

    // Realign, then a realign on the cycle of the 8th match.
    drive(w5, 1, 1, 1);
    for (int i = 0; i < 7; i++) drive(w5, 1, 1, 0);
    drive(w5, 1, 1, 1);
    settle();
    check("realign_locked", locked, 0);
`ifdef LVDS_ALIGN_ERR_CNT_EN
    check("realign_err", err_cnt, 0);
`endif
    for (int i = 0; i < 9; i++) drive(w5, 1, 1, 0);
    settle();
    check("relock_locked", locked, 1);

    // Randomised streams at random offsets with corruption, gaps and occasional realign.
    for (int blk = 0; blk < 15; blk++) begin
      s = $urandom_range(0, 11);
      w = rotl(PAT, s);
      if (blk == 7) do_reset("reset_mid");
      for (int i = 0; i < 200; i++) begin
        r = $urandom_range(0, 99);
        d = w;
        if (r < 8)       d = w ^ 12'($urandom_range(1, 4095));
        else if (r < 12) d = 12'($urandom);
        v  = ($urandom_range(0, 99) < 85);
        tr = ($urandom_range(0, 99) < 85);
        ra = ($urandom_range(0, 199) == 0);
        drive(d, v, tr, ra);
      end
    end

    settle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
